// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, variable-latency data-memory access
// with timeout, MEM/WB register, branch resolution and forwarding outputs.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_ALU_result,
    input  logic        EX_zero,
    input  logic        EX_branch,
    input  logic        EX_unconditional_jmp,
    input  logic        EX_memread,
    input  logic        EX_memwrite,
    input  logic        EX_memtoreg,
    input  logic        EX_regwrite,
    input  logic [4:0]  EX_rd,
    input  logic [31:0] EX_rs2_data,
    input  logic        EX_stall,
    output logic [31:0] EX_MEM_ALU_result,
    output logic [4:0]  EX_MEM_rd,
    output logic        EX_MEM_regwrite,
    output logic        EX_MEM_memtoreg,
    mem_stage_if.master dmem,
    output logic        MEM_stall,
    output logic        MEM_branch_taken,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_regwrite,
    output logic [31:0] MEM_WB_result,
    output logic        MEM_bus_error,
    output logic        MEM_bus_error_sticky
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_alu, r_wdata;
    logic [4:0]  r_rd;
    logic        r_zero, r_branch, r_jmp, r_memread, r_memwrite, r_memtoreg, r_regwrite;
    logic [4:0]  r_wb_rd;
    logic        r_wb_regwrite;
    logic [31:0] r_wb_result;
    logic        r_bus_err, r_bus_err_sticky;

    logic        w_in_access, w_timeout, w_stall, w_taken, w_bubble, w_cap_mem;
    logic [31:0] w_load_data;

    // Handshake decode: stall, timeout, branch resolution and capture qualifiers.
    always_comb begin
        w_in_access = (r_state == ST_ACCESS);
        w_timeout   = w_in_access & (r_cnt == TO_LAST) & ~dmem.dmem_ack;
        w_stall     = w_in_access & ~dmem.dmem_ack & ~w_timeout;
        w_taken     = r_jmp | (r_branch & r_zero);
        w_bubble    = w_taken | EX_stall;
        w_cap_mem   = ~w_stall & ~w_bubble & (EX_memread | EX_memwrite);
        // A timed-out load completes with zero data.
        w_load_data = (w_in_access & dmem.dmem_ack) ? dmem.dmem_rdata : 32'h0000_0000;
    end

    // Access FSM next state and wait counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_cap_mem) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_stall) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end else if (w_cap_mem) begin
                    w_state_nxt = ST_ACCESS;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // EX/MEM register: frozen while stalled, bubble on flush or load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu <= 32'h0; r_wdata <= 32'h0; r_rd <= 5'd0;
            r_zero <= 1'b0; r_branch <= 1'b0; r_jmp <= 1'b0;
            r_memread <= 1'b0; r_memwrite <= 1'b0; r_memtoreg <= 1'b0; r_regwrite <= 1'b0;
        end else if (!w_stall) begin
            if (w_bubble) begin
                r_alu <= 32'h0; r_wdata <= 32'h0; r_rd <= 5'd0;
                r_zero <= 1'b0; r_branch <= 1'b0; r_jmp <= 1'b0;
                r_memread <= 1'b0; r_memwrite <= 1'b0; r_memtoreg <= 1'b0; r_regwrite <= 1'b0;
            end else begin
                r_alu <= EX_ALU_result; r_wdata <= EX_rs2_data; r_rd <= EX_rd;
                r_zero <= EX_zero; r_branch <= EX_branch; r_jmp <= EX_unconditional_jmp;
                r_memread <= EX_memread; r_memwrite <= EX_memwrite;
                r_memtoreg <= EX_memtoreg; r_regwrite <= EX_regwrite;
            end
        end
    end

    // MEM/WB register, updated whenever the stage is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_rd       <= 5'd0;
            r_wb_regwrite <= 1'b0;
            r_wb_result   <= 32'h0;
        end else if (!w_stall) begin
            r_wb_rd       <= r_rd;
            r_wb_regwrite <= r_regwrite & ~r_memwrite;
            r_wb_result   <= r_memtoreg ? w_load_data : r_alu;
        end
    end

    // Bus-error pulse and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_err        <= 1'b0;
            r_bus_err_sticky <= 1'b0;
        end else begin
            r_bus_err        <= w_timeout;
            r_bus_err_sticky <= r_bus_err_sticky | w_timeout;
        end
    end

    assign dmem.dmem_req        = w_in_access;
    assign dmem.dmem_we         = r_memwrite;
    assign dmem.dmem_addr       = r_alu;
    assign dmem.dmem_wdata      = r_wdata;
    assign EX_MEM_ALU_result    = r_alu;
    assign EX_MEM_rd            = r_rd;
    assign EX_MEM_regwrite      = r_regwrite;
    assign EX_MEM_memtoreg      = r_memtoreg;
    assign MEM_stall            = w_stall;
    assign MEM_branch_taken     = w_taken;
    assign MEM_WB_rd            = r_wb_rd;
    assign MEM_WB_regwrite      = r_wb_regwrite;
    assign MEM_WB_result        = r_wb_result;
    assign MEM_bus_error        = r_bus_err;
    assign MEM_bus_error_sticky = r_bus_err_sticky;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a transaction-level model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_mem_stage;
    localparam int ACK_TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ex_alu = 32'h0, ex_wd = 32'h0;
    logic [4:0]  ex_rd = 5'd0;
    logic        ex_zero = 1'b0, ex_br = 1'b0, ex_jmp = 1'b0, ex_mr = 1'b0, ex_mw = 1'b0;
    logic        ex_mtr = 1'b0, ex_rw = 1'b0, ex_stall = 1'b0;

    logic [31:0] exmem_alu, wb_res;
    logic [4:0]  exmem_rd, wb_rd;
    logic        exmem_rw, exmem_mtr, stall, taken, wb_rw, berr, berr_st;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if bus();

    mem_stage #(.ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .EX_ALU_result(ex_alu), .EX_zero(ex_zero), .EX_branch(ex_br),
        .EX_unconditional_jmp(ex_jmp), .EX_memread(ex_mr), .EX_memwrite(ex_mw),
        .EX_memtoreg(ex_mtr), .EX_regwrite(ex_rw), .EX_rd(ex_rd),
        .EX_rs2_data(ex_wd), .EX_stall(ex_stall),
        .EX_MEM_ALU_result(exmem_alu), .EX_MEM_rd(exmem_rd),
        .EX_MEM_regwrite(exmem_rw), .EX_MEM_memtoreg(exmem_mtr),
        .dmem(bus.master),
        .MEM_stall(stall), .MEM_branch_taken(taken),
        .MEM_WB_rd(wb_rd), .MEM_WB_regwrite(wb_rw), .MEM_WB_result(wb_res),
        .MEM_bus_error(berr), .MEM_bus_error_sticky(berr_st)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_alu, m_wd, m_wb_res;
    logic [4:0]  m_rd, m_wb_rd;
    logic        m_zero, m_br, m_jmp, m_mr, m_mw, m_mtr, m_rw, m_wb_rw;
    logic        m_busy, m_err, m_sticky;
    int          m_waited;
    logic        e_timeout, e_stall, e_taken;

    always_comb begin
        e_taken   = m_jmp || (m_br && m_zero);
        e_timeout = m_busy && !bus.dmem_ack && (m_waited >= ACK_TO - 1);
        e_stall   = m_busy && !bus.dmem_ack && !e_timeout;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_alu <= 32'h0; m_wd <= 32'h0; m_rd <= 5'd0;
            m_zero <= 1'b0; m_br <= 1'b0; m_jmp <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
            m_mtr <= 1'b0; m_rw <= 1'b0; m_busy <= 1'b0; m_waited <= 0;
            m_wb_res <= 32'h0; m_wb_rd <= 5'd0; m_wb_rw <= 1'b0;
            m_err <= 1'b0; m_sticky <= 1'b0;
        end else begin
            m_err <= e_timeout;
            if (e_timeout) m_sticky <= 1'b1;
            if (!e_stall) begin
                m_wb_rd  <= m_rd;
                m_wb_rw  <= m_rw && !m_mw;
                m_wb_res <= m_mtr ? ((m_busy && bus.dmem_ack) ? bus.dmem_rdata : 32'h0) : m_alu;
                m_waited <= 0;
                if (e_taken || ex_stall) begin
                    m_alu <= 32'h0; m_wd <= 32'h0; m_rd <= 5'd0;
                    m_zero <= 1'b0; m_br <= 1'b0; m_jmp <= 1'b0; m_mr <= 1'b0; m_mw <= 1'b0;
                    m_mtr <= 1'b0; m_rw <= 1'b0; m_busy <= 1'b0;
                end else begin
                    m_alu <= ex_alu; m_wd <= ex_wd; m_rd <= ex_rd;
                    m_zero <= ex_zero; m_br <= ex_br; m_jmp <= ex_jmp; m_mr <= ex_mr; m_mw <= ex_mw;
                    m_mtr <= ex_mtr; m_rw <= ex_rw; m_busy <= ex_mr || ex_mw;
                end
            end else begin
                m_waited <= m_waited + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("m_req", bus.dmem_req, m_busy);
        check("m_addr", bus.dmem_addr, m_alu);
        if (bus.dmem_req) begin
            check("m_we", bus.dmem_we, m_mw);
            check("m_wdata", bus.dmem_wdata, m_wd);
        end
        check("m_stall", stall, e_stall);
        check("m_taken", taken, e_taken);
        check("m_exmem_rd", exmem_rd, m_rd);
        check("m_exmem_rw", exmem_rw, m_rw);
        check("m_exmem_mtr", exmem_mtr, m_mtr);
        check("m_wb_rd", wb_rd, m_wb_rd);
        check("m_wb_rw", wb_rw, m_wb_rw);
        check("m_wb_res", wb_res, m_wb_res);
        check("m_err", berr, m_err);
        check("m_sticky", berr_st, m_sticky);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] wd,
                         input logic mr, input logic mw, input logic mtr, input logic rw,
                         input logic br, input logic z, input logic j, input logic st);
        ex_alu = alu; ex_rd = rd; ex_wd = wd; ex_mr = mr; ex_mw = mw; ex_mtr = mtr;
        ex_rw = rw; ex_br = br; ex_zero = z; ex_jmp = j; ex_stall = st;
    endtask

    task automatic nop();
        drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int req_cnt, stall_cnt, err_cnt;

    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        #3;
        check("rst_req", bus.dmem_req, 32'h0);
        check("rst_stall", stall, 32'h0);
        check("rst_wb_res", wb_res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // ADD rd=5, result 0x12
        drive(32'h0000_0012, 5'd5, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        nop();
        @(negedge clk);
        check("add_exmem_rd", exmem_rd, 32'd5);
        check("add_stall", stall, 32'h0);
        next_cycle();
        @(negedge clk);
        check("add_wb_res", wb_res, 32'h12);
        check("add_wb_rw", wb_rw, 32'h1);

        // Load 0x100 -> rd 7, ack on the third ACCESS cycle
        next_cycle();
        drive(32'h0000_0100, 5'd7, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        req_cnt = 0; stall_cnt = 0;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            #1;
            nop();
            bus.dmem_ack   = (k == 3);
            bus.dmem_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            req_cnt   = req_cnt + int'(bus.dmem_req);
            stall_cnt = stall_cnt + int'(stall);
            if (k == 1) check("ld_we", bus.dmem_we, 32'h0);
            if (k == 4) begin
                check("ld_wb_res", wb_res, 32'hDEAD_BEEF);
                check("ld_wb_rw", wb_rw, 32'h1);
                check("ld_wb_rd", wb_rd, 32'd7);
            end
            @(posedge clk);
        end
        check("ld_req_cycles", req_cnt, 32'd3);
        check("ld_stall_cycles", stall_cnt, 32'd2);

        // Store 0xCAFE0001 to 0x40 with zero-wait ack, then a load back-to-back
        #1;
        drive(32'h0000_0040, 5'd0, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        drive(32'h0000_0080, 5'd9, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        check("st_stall", stall, 32'h0);
        check("st_we", bus.dmem_we, 32'h1);
        check("st_wdata", bus.dmem_wdata, 32'hCAFE_0001);
        check("st_addr", bus.dmem_addr, 32'h40);
        next_cycle();
        nop();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("b2b_req", bus.dmem_req, 32'h1);
        check("b2b_we", bus.dmem_we, 32'h0);
        check("st_wb_rw", wb_rw, 32'h0);
        next_cycle();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        check("b2b_wb_res", wb_res, 32'h1234_5678);
        check("b2b_req_done", bus.dmem_req, 32'h0);

        // Load 0x200 with no ack: timeout after ACK_TO-1 stall cycles
        next_cycle();
        drive(32'h0000_0200, 5'd3, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stall_cnt = 0; err_cnt = 0;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            #1;
            nop();
            @(negedge clk);
            stall_cnt = stall_cnt + int'(stall);
            err_cnt   = err_cnt + int'(berr);
            if (k == 5) begin
                check("to_err_pulse", berr, 32'h1);
                check("to_wb_res", wb_res, 32'h0);
                check("to_wb_rw", wb_rw, 32'h1);
            end
            @(posedge clk);
        end
        check("to_stall_cycles", stall_cnt, 32'd3);
        check("to_err_count", err_cnt, 32'd1);
        check("to_sticky", berr_st, 32'h1);

        // BEQ taken: the following ADD becomes a bubble
        #1;
        drive(32'h0000_0000, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(32'h0000_0055, 5'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("beq_taken", taken, 32'h1);
        next_cycle();
        nop();
        @(negedge clk);
        check("beq_taken_clr", taken, 32'h0);
        check("beq_bubble_rw", exmem_rw, 32'h0);
        check("beq_bubble_rd", exmem_rd, 32'd0);
        next_cycle();
        @(negedge clk);
        check("beq_wb_rw", wb_rw, 32'h0);

        // ADD under EX_stall captures a bubble
        next_cycle();
        drive(32'h0000_0077, 5'd6, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        next_cycle();
        nop();
        @(negedge clk);
        check("exst_bubble_rw", exmem_rw, 32'h0);
        check("exst_bubble_alu", exmem_alu, 32'h0);
        next_cycle();
        @(negedge clk);
        check("exst_wb_rw", wb_rw, 32'h0);

        // Reset in the second ACCESS cycle of a load, then a late ack
        next_cycle();
        drive(32'h0000_0300, 5'd8, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        next_cycle();
        nop();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rst2_req", bus.dmem_req, 32'h0);
        check("rst2_stall", stall, 32'h0);
        check("rst2_exmem_rd", exmem_rd, 32'd0);
        check("rst2_sticky", berr_st, 32'h0);
        check("rst2_taken", taken, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 32'h0000_0BAD;
        next_cycle();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'h0;
        @(negedge clk);
        check("late_ack_wb_rw", wb_rw, 32'h0);
        check("late_ack_wb_res", wb_res, 32'h0);
        check("late_ack_req", bus.dmem_req, 32'h0);

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
